// File: rtl/mem_responder_if.sv
// Valid/ready memory bus between the core (master) and the responder (slave).
// mem_fault exists only when MEM_RESPONDER_FAULT_EN is defined.
interface mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef MEM_RESPONDER_FAULT_EN
  logic        mem_fault;

  modport master (
    output mem_valid, mem_instr, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_fault
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_fault
  );
`else
  modport master (
    output mem_valid, mem_instr, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// Word RAM responder with programmable wait states on the core memory bus.
// Optional out-of-range fault pulse: define MEM_RESPONDER_FAULT_EN.
module mem_responder #(
  parameter int unsigned WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned LATENCY   = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int unsigned AW  = $clog2(WORDS);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          inr_q, inr_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   ram_q [WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] a_idx;
  logic          a_inr;
  logic          unused_lsb;

  assign offset     = bus.mem_addr - BASE_ADDR;
  assign a_idx      = offset[AW+1:2];
  assign a_inr      = offset[31:AW+2] == '0;
  assign unused_lsb = ^offset[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    inr_d   = inr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          idx_d   = a_idx;
          inr_d   = a_inr;
          wr_d    = !bus.mem_instr &&
                    (bus.mem_wstrb != 4'b0);
          wdata_d = bus.mem_wdata;
          wstrb_d = bus.mem_wstrb;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Read data is latched on the edge entering RESP only
    if (state_d == RESP && state_q != RESP &&
        !wr_d && inr_d)
      rdata_d = ram_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      inr_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      inr_q   <= inr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP &&
        wr_q && inr_q) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_q[k])
          ram_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.mem_ready = state_q == RESP;
  assign bus.mem_rdata = rdata_q;
`ifdef MEM_RESPONDER_FAULT_EN
  assign bus.mem_fault = (state_q == RESP) && !inr_q;
`endif
endmodule
